// File: rtl/voice_ack_tx.sv
// UART acknowledgement transmitter: sends "OK1"/"OK0" (8N1, LSB first) on key pulses,
// with a one-entry pending slot. Define VOICE_ACK_CRLF_EN to append CR LF to each frame.
module voice_ack_tx #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 9600
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_flag1,
    input  logic key_flag2,
    output logic tx,
    output logic busy
);

    localparam int BIT_CNT = CLK_FREQ / BAUD;
    localparam int CW      = (BIT_CNT > 1) ? $clog2(BIT_CNT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(BIT_CNT - 1);
`ifdef VOICE_ACK_CRLF_EN
    localparam logic [2:0] LAST_BYTE = 3'd4;
`else
    localparam logic [2:0] LAST_BYTE = 3'd2;
`endif

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, NEXT} state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_baud;
    logic [2:0]      r_bit;
    logic [2:0]      r_byte;
    logic            r_sel;
    logic            r_pend_vld;
    logic            r_pend_sel;
    logic            r_tx;
    logic            r_busy;

    logic            w_flag;
    logic            w_bit_end;
    logic            w_last_byte;
    logic [2:0]      w_bit_inc;
    logic [7:0]      w_cur_byte;
    logic            w_tx_nxt;
    logic            w_new_frame;
    logic            w_new_sel;

    // r_sel=1 selects the "on" digit '1', otherwise '0'
    function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic sel);
        case (idx)
            3'd0:    frame_byte = 8'h4F;
            3'd1:    frame_byte = 8'h4B;
            3'd2:    frame_byte = sel ? 8'h31 : 8'h30;
            3'd3:    frame_byte = 8'h0D;
            3'd4:    frame_byte = 8'h0A;
            default: frame_byte = 8'hFF;
        endcase
    endfunction

    assign w_flag      = key_flag1 | key_flag2;
    assign w_bit_end   = (r_baud == BAUD_LAST);
    assign w_last_byte = (r_byte == LAST_BYTE);
    assign w_bit_inc   = r_bit + 3'd1;
    assign w_cur_byte  = frame_byte(r_byte, r_sel);

    always_comb begin
        w_state_nxt = r_state;
        w_tx_nxt    = r_tx;
        w_new_frame = 1'b0;
        w_new_sel   = key_flag1;
        case (r_state)
            IDLE: if (w_flag) begin
                w_state_nxt = START;
                w_tx_nxt    = 1'b0;
                w_new_frame = 1'b1;
            end
            START: if (w_bit_end) begin
                w_state_nxt = DATA;
                w_tx_nxt    = w_cur_byte[0];
            end
            DATA: if (w_bit_end) begin
                if (r_bit == 3'd7) begin
                    w_state_nxt = STOP;
                    w_tx_nxt    = 1'b1;
                end else begin
                    w_tx_nxt    = w_cur_byte[w_bit_inc];
                end
            end
            STOP: if (w_bit_end) w_state_nxt = NEXT;
            NEXT: begin
                if (!w_last_byte) begin
                    w_state_nxt = START;
                    w_tx_nxt    = 1'b0;
                end else if (w_flag || r_pend_vld) begin
                    // a flag seen this cycle is newer than the slot, so it wins
                    w_state_nxt = START;
                    w_tx_nxt    = 1'b0;
                    w_new_frame = 1'b1;
                    w_new_sel   = w_flag ? key_flag1 : r_pend_sel;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_baud     <= '0;
            r_bit      <= '0;
            r_byte     <= '0;
            r_sel      <= 1'b0;
            r_pend_vld <= 1'b0;
            r_pend_sel <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tx    <= w_tx_nxt;
            r_busy  <= (w_state_nxt != IDLE);

            if (r_state == START || r_state == DATA || r_state == STOP)
                r_baud <= w_bit_end ? '0 : r_baud + CW'(1);
            else
                r_baud <= '0;

            if (r_state == DATA && w_bit_end)
                r_bit <= w_bit_inc;

            if (w_new_frame || (r_state == NEXT && w_last_byte))
                r_byte <= '0;
            else if (r_state == NEXT)
                r_byte <= r_byte + 3'd1;

            if (w_new_frame)
                r_sel <= w_new_sel;

            if (w_new_frame) begin
                r_pend_vld <= 1'b0;
            end else if (w_flag && r_state != IDLE) begin
                r_pend_vld <= 1'b1;
                r_pend_sel <= key_flag1;
            end
        end
    end

    assign tx   = r_tx;
    assign busy = r_busy;

endmodule

// File: tb/tb_voice_ack_tx.sv
// Bench for voice_ack_tx: table-driven frame decode, hand-written corner sequences and
// random flag traffic checked cycle by cycle against a waveform-queue reference model.
module tb_voice_ack_tx;

    localparam int CLK_FREQ = 1000;
    localparam int BAUD     = 100;
    localparam int BIT      = CLK_FREQ / BAUD;
    localparam int BYTE_LEN = 10 * BIT + 1;
`ifdef VOICE_ACK_CRLF_EN
    localparam int NB = 5;
`else
    localparam int NB = 3;
`endif
    localparam int FLEN   = NB * BYTE_LEN;
    localparam int CAPMAX = 4096;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic key_flag1 = 1'b0;
    logic key_flag2 = 1'b0;
    logic tx;
    logic busy;

    voice_ack_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk(clk), .rst_n(rst_n), .key_flag1(key_flag1), .key_flag2(key_flag2),
        .tx(tx), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model: expected tx waveform as a queue ----------------
    logic q[$];
    logic m_pend_vld = 1'b0;
    logic m_pend_sel = 1'b0;
    logic exp_tx = 1'b1;
    logic exp_busy = 1'b0;
    int   tx_err = 0;
    int   busy_err = 0;

    function automatic logic [7:0] ref_byte(input int k, input logic sel);
        logic [7:0] tbl [5];
        tbl = '{8'h4F, 8'h4B, 8'h30, 8'h0D, 8'h0A};
        if (k == 2) return sel ? 8'h31 : 8'h30;
        return tbl[k];
    endfunction

    task automatic push_frame(input logic sel);
        logic [7:0] b;
        for (int k = 0; k < NB; k++) begin
            b = ref_byte(k, sel);
            repeat (BIT) q.push_back(1'b0);
            for (int i = 0; i < 8; i++) repeat (BIT) q.push_back(b[i]);
            repeat (BIT) q.push_back(1'b1);
            q.push_back(1'b1);
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            q.delete();
            m_pend_vld = 1'b0;
            exp_tx = 1'b1;
            exp_busy = 1'b0;
        end else begin
            if (q.size() == 0) begin
                if (key_flag1 | key_flag2) push_frame(key_flag1);
                else if (m_pend_vld) push_frame(m_pend_sel);
                m_pend_vld = 1'b0;
            end else if (key_flag1 | key_flag2) begin
                m_pend_vld = 1'b1;
                m_pend_sel = key_flag1;
            end
            if (q.size() > 0) begin
                exp_tx = q.pop_front();
                exp_busy = 1'b1;
            end else begin
                exp_tx = 1'b1;
                exp_busy = 1'b0;
            end
        end
    end

    // ---------------- checker + capture of busy-period tx samples ----------------
    logic cap [0:CAPMAX-1];
    int   cap_n = 0;

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (tx !== exp_tx) tx_err++;
            if (busy !== exp_busy) busy_err++;
            if (busy === 1'b1 && cap_n < CAPMAX) begin
                cap[cap_n] = tx;
                cap_n++;
            end
        end
    end

    function automatic logic [7:0] byte_at(input int base, input int k);
        logic [7:0] d;
        for (int b = 0; b < 8; b++) d[b] = cap[base + k * BYTE_LEN + BIT + BIT / 2 + b * BIT];
        return d;
    endfunction

    task automatic check_frame(input string name, input int base, input logic [7:0] digit);
        check({name, " start_bit"}, {31'd0, cap[base + BIT / 2]}, 32'd0);
        check({name, " byte0"}, {24'd0, byte_at(base, 0)}, 32'h4F);
        check({name, " byte1"}, {24'd0, byte_at(base, 1)}, 32'h4B);
        check({name, " byte2"}, {24'd0, byte_at(base, 2)}, {24'd0, digit});
`ifdef VOICE_ACK_CRLF_EN
        check({name, " byte3"}, {24'd0, byte_at(base, 3)}, 32'h0D);
        check({name, " byte4"}, {24'd0, byte_at(base, 4)}, 32'h0A);
`endif
        check({name, " stop_bit"}, {31'd0, cap[base + 9 * BIT + BIT / 2]}, 32'd1);
    endtask

    task automatic pulse(input logic a, input logic b);
        @(negedge clk);
        key_flag1 = a;
        key_flag2 = b;
        @(negedge clk);
        key_flag1 = 1'b0;
        key_flag2 = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n = 0;
        while (busy !== 1'b0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s timeout: busy still high after %0d cycles", name, limit);
        end
    endtask

    typedef struct {
        logic       k1;
        logic       k2;
        logic [7:0] digit;
        int         len;
    } vec_t;

    vec_t vecs [3];

    initial begin
        logic [1:0] r;
        vecs[0] = '{k1: 1'b1, k2: 1'b0, digit: 8'h31, len: FLEN};
        vecs[1] = '{k1: 1'b0, k2: 1'b1, digit: 8'h30, len: FLEN};
        vecs[2] = '{k1: 1'b1, k2: 1'b1, digit: 8'h31, len: FLEN};

        // flags held during reset must be ignored
        key_flag1 = 1'b1;
        key_flag2 = 1'b1;
        repeat (3) @(negedge clk);
        check("reset tx", {31'd0, tx}, 32'd1);
        check("reset busy", {31'd0, busy}, 32'd0);
        key_flag1 = 1'b0;
        key_flag2 = 1'b0;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("post-reset busy", {31'd0, busy}, 32'd0);
        check("post-reset tx", {31'd0, tx}, 32'd1);

        foreach (vecs[i]) begin
            cap_n = 0;
            pulse(vecs[i].k1, vecs[i].k2);
            wait_idle($sformatf("vec%0d", i), 2 * FLEN);
            check($sformatf("vec%0d busy_len", i), cap_n, vecs[i].len);
            check_frame($sformatf("vec%0d", i), 0, vecs[i].digit);
            repeat (3) @(negedge clk);
        end

        // overwrite of the pending slot: last flag wins, frames back to back
        cap_n = 0;
        pulse(1'b1, 1'b0);
        repeat (50) @(negedge clk);
        pulse(1'b0, 1'b1);
        repeat (100) @(negedge clk);
        pulse(1'b1, 1'b0);
        wait_idle("pend_overwrite", 3 * FLEN);
        check("pend_overwrite busy_len", cap_n, 2 * FLEN);
        check_frame("pend_overwrite f0", 0, 8'h31);
        check_frame("pend_overwrite f1", FLEN, 8'h31);
        repeat (3) @(negedge clk);

        // flag sampled on the final NEXT edge starts without a gap
        cap_n = 0;
        pulse(1'b1, 1'b0);
        repeat (FLEN - 2) @(negedge clk);
        pulse(1'b0, 1'b1);
        wait_idle("next_edge", 3 * FLEN);
        check("next_edge busy_len", cap_n, 2 * FLEN);
        check_frame("next_edge f1", FLEN, 8'h30);
        repeat (3) @(negedge clk);

        // reset mid-frame
        pulse(1'b1, 1'b0);
        repeat (149) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset tx", {31'd0, tx}, 32'd1);
        check("midreset busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("after_reset idle tx", {31'd0, tx}, 32'd1);
        check("after_reset idle busy", {31'd0, busy}, 32'd0);
        cap_n = 0;
        pulse(1'b0, 1'b1);
        wait_idle("after_reset", 2 * FLEN);
        check("after_reset busy_len", cap_n, FLEN);
        check_frame("after_reset", 0, 8'h30);

        // random flag traffic against the model
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 350)) @(negedge clk);
            r = 2'($urandom_range(1, 3));
            pulse(r[0], r[1]);
        end
        wait_idle("random", 4 * FLEN);
        repeat (3) @(negedge clk);

        check("model tx mismatches", tx_err, 0);
        check("model busy mismatches", busy_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
